// File: rtl/wb_result_arbiter.sv
// wb_result_arbiter
//   Collects execution-unit results over valid/ready, buffers them in one small FIFO
//   per unit and drives up to WB_WIDTH registered physical-regfile writes per cycle.
//   Units are granted round-robin starting at rr_ptr; the k-th grant lands on lane k.
//   Optional feature macro: WB_ARB_BYPASS_EN -- a valid result from a unit whose FIFO
//   is empty may be granted in its arrival cycle and written straight to the output
//   registers (1-cycle latency). Undefined (default): every result goes through its FIFO.
module wb_result_arbiter #(
  parameter int EU_NUM           = 4,
  parameter int WB_WIDTH         = 2,
  parameter int FIFO_DEPTH       = 2,
  parameter int PHY_REG_ID_WIDTH = 6,
  parameter int REG_DATA_WIDTH   = 32
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           flush,
  input  logic [EU_NUM-1:0]                              eu_wb_valid,
  output logic [EU_NUM-1:0]                              eu_wb_ready,
  input  logic [EU_NUM-1:0][PHY_REG_ID_WIDTH-1:0]        eu_wb_id,
  input  logic [EU_NUM-1:0][REG_DATA_WIDTH-1:0]          eu_wb_data,
  output logic [WB_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]      wb_phyf_id,
  output logic [WB_WIDTH-1:0][REG_DATA_WIDTH-1:0]        wb_phyf_data,
  output logic [WB_WIDTH-1:0]                            wb_phyf_we
);

  localparam int EU_IDX_W = (EU_NUM > 1) ? $clog2(EU_NUM) : 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);

  logic [PHY_REG_ID_WIDTH-1:0] fifo_id_q   [EU_NUM][FIFO_DEPTH];
  logic [PHY_REG_ID_WIDTH-1:0] fifo_id_d   [EU_NUM][FIFO_DEPTH];
  logic [REG_DATA_WIDTH-1:0]   fifo_data_q [EU_NUM][FIFO_DEPTH];
  logic [REG_DATA_WIDTH-1:0]   fifo_data_d [EU_NUM][FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_q    [EU_NUM];
  logic [PTR_W-1:0]            wr_ptr_d    [EU_NUM];
  logic [PTR_W-1:0]            rd_ptr_q    [EU_NUM];
  logic [PTR_W-1:0]            rd_ptr_d    [EU_NUM];
  logic [CNT_W-1:0]            count_q     [EU_NUM];
  logic [CNT_W-1:0]            count_d     [EU_NUM];
  logic [EU_IDX_W-1:0]         rr_ptr_q, rr_ptr_d;

  logic [WB_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0] wb_id_q, wb_id_d;
  logic [WB_WIDTH-1:0][REG_DATA_WIDTH-1:0]   wb_data_q, wb_data_d;
  logic [WB_WIDTH-1:0]                       wb_we_q, wb_we_d;

  logic [EU_NUM-1:0]   grant_s;
  logic [EU_NUM-1:0]   bypass_s;
  logic [EU_NUM-1:0]   push_s;
  logic [EU_NUM-1:0]   pop_s;
  logic [EU_IDX_W-1:0] last_s;
  logic                any_grant_s;

  assign wb_phyf_id   = wb_id_q;
  assign wb_phyf_data = wb_data_q;
  assign wb_phyf_we   = wb_we_q;

  // Ready reflects FIFO room only (never valid); a full FIFO stays not-ready even while popping.
  always_comb begin
    eu_wb_ready = '0;
    for (int e = 0; e < EU_NUM; e++) begin
      if (rst) begin
        eu_wb_ready[e] = 1'b0;
      end else begin
        eu_wb_ready[e] = (count_q[e] < CNT_W'(FIFO_DEPTH));
      end
    end
  end

  // Round-robin scan from rr_ptr: first WB_WIDTH qualifying units get lanes 0..WB_WIDTH-1.
  always_comb begin
    logic [EU_IDX_W-1:0] e;
    logic                qual;
    int                  n;
    e           = '0;
    qual        = 1'b0;
    n           = 0;
    grant_s     = '0;
    bypass_s    = '0;
    last_s      = rr_ptr_q;
    any_grant_s = 1'b0;
    wb_we_d     = '0;
    wb_id_d     = '0;
    wb_data_d   = '0;
    for (int i = 0; i < EU_NUM; i++) begin
      e = EU_IDX_W'((int'(rr_ptr_q) + i) % EU_NUM);
`ifdef WB_ARB_BYPASS_EN
      qual = (count_q[e] != '0) || (eu_wb_valid[e] && eu_wb_ready[e]);
`else
      qual = (count_q[e] != '0);
`endif
      if (qual && (n < WB_WIDTH) && !flush) begin
        grant_s[e]  = 1'b1;
        bypass_s[e] = (count_q[e] == '0);
        last_s      = e;
        any_grant_s = 1'b1;
        for (int k = 0; k < WB_WIDTH; k++) begin
          if (k == n) begin
            wb_we_d[k] = 1'b1;
            if (count_q[e] == '0) begin
              wb_id_d[k]   = eu_wb_id[e];
              wb_data_d[k] = eu_wb_data[e];
            end else begin
              wb_id_d[k]   = fifo_id_q[e][rd_ptr_q[e]];
              wb_data_d[k] = fifo_data_q[e][rd_ptr_q[e]];
            end
          end else begin
            wb_we_d[k] = wb_we_d[k];
          end
        end
        n = n + 1;
      end else begin
        n = n;
      end
    end
  end

  // FIFO push/pop bookkeeping and next round-robin pointer; flush clears everything.
  always_comb begin
    fifo_id_d   = fifo_id_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    push_s      = '0;
    pop_s       = '0;
    for (int e = 0; e < EU_NUM; e++) begin
      push_s[e] = eu_wb_valid[e] && eu_wb_ready[e] && !flush && !bypass_s[e];
      pop_s[e]  = grant_s[e] && !bypass_s[e];
      if (flush) begin
        wr_ptr_d[e] = '0;
        rd_ptr_d[e] = '0;
        count_d[e]  = '0;
      end else begin
        if (push_s[e]) begin
          fifo_id_d[e][wr_ptr_q[e]]   = eu_wb_id[e];
          fifo_data_d[e][wr_ptr_q[e]] = eu_wb_data[e];
          wr_ptr_d[e]                 = wr_ptr_q[e] + PTR_W'(1);
        end else begin
          wr_ptr_d[e] = wr_ptr_q[e];
        end
        if (pop_s[e]) begin
          rd_ptr_d[e] = rd_ptr_q[e] + PTR_W'(1);
        end else begin
          rd_ptr_d[e] = rd_ptr_q[e];
        end
        count_d[e] = count_q[e] + CNT_W'(push_s[e]) - CNT_W'(pop_s[e]);
      end
    end
    if (flush) begin
      rr_ptr_d = '0;
    end else if (any_grant_s) begin
      rr_ptr_d = (last_s == EU_IDX_W'(EU_NUM - 1)) ? '0 : last_s + EU_IDX_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < EU_NUM; e++) begin
        wr_ptr_q[e] <= '0;
        rd_ptr_q[e] <= '0;
        count_q[e]  <= '0;
      end
      rr_ptr_q  <= '0;
      wb_we_q   <= '0;
      wb_id_q   <= '0;
      wb_data_q <= '0;
    end else begin
      fifo_id_q   <= fifo_id_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rr_ptr_q    <= rr_ptr_d;
      wb_we_q     <= wb_we_d;
      wb_id_q     <= wb_id_d;
      wb_data_q   <= wb_data_d;
    end
  end

endmodule
